// File: rtl/m16_pkg.sv
// Constants and types shared by the M16 imitator frame-RAM writer and reader.
package m16_pkg;

  localparam int M16_ADDR_W    = 11;
  localparam int M16_DATA_W    = 12;
  localparam int M16_HALF_SIZE = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SHIFT = 2'd2
  } rd_state_e;

endpackage

// File: rtl/manchester_encoder.sv
// Manchester half-bit generator: a loaded bit is driven as-is for HALF_PERIOD
// clocks, then inverted for HALF_PERIOD clocks; bit_done_o marks the final clock.
module manchester_encoder #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic bit_i,
  input  logic load_i,
  output logic dout_o,
  output logic bit_done_o
);

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

  logic [PH_W-1:0] ph_q, ph_d;
  logic            half_q, half_d;
  logic            bit_q, bit_d;

  always_comb begin
    ph_d   = ph_q;
    half_d = half_q;
    bit_d  = bit_q;
    if (load_i) begin
      bit_d  = bit_i;
      ph_d   = '0;
      half_d = 1'b0;
    end else if (ph_q == PH_LAST) begin
      ph_d   = '0;
      half_d = ~half_q;
    end else begin
      ph_d = ph_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ph_q   <= '0;
      half_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      half_q <= half_d;
    end
  end

  always_ff @(posedge clk_i) begin
    bit_q <= bit_d;
  end

  assign dout_o     = bit_q ^ half_q;
  assign bit_done_o = half_q && (ph_q == PH_LAST);

endmodule

// File: rtl/ram_frame_reader.sv
// Streams 12-bit words from the frame RAM as a gapless MSB-first Manchester line,
// toggling buf_switch as each half-buffer is consumed so the writer can refill it.
module ram_frame_reader
  import m16_pkg::*;
#(
  parameter int ADDR_W      = M16_ADDR_W,
  parameter int DATA_W      = M16_DATA_W,
  parameter int HALF_SIZE   = M16_HALF_SIZE,
  parameter int HALF_PERIOD = 2,
  parameter int RD_LAT      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] rdaddress,
  output logic              dout,
  output logic              word_strobe,
  output logic              buf_switch,
  output logic              busy
);

  localparam int WORD_CLKS = DATA_W * 2 * HALF_PERIOD;
  localparam int CYC_W     = $clog2(WORD_CLKS);
  localparam int PC_W      = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST    = CYC_W'(WORD_CLKS - 1);
  localparam logic [CYC_W-1:0] CYC_PRELAST = CYC_W'(WORD_CLKS - 2);
  localparam logic [CYC_W-1:0] CYC_FETCH   = CYC_W'(RD_LAT + 1);
  localparam logic [PC_W-1:0]  PC_LAST     = PC_W'(RD_LAT);

  // The prefetch slot must land strictly before the word's last clock.
  if (WORD_CLKS <= RD_LAT + 2) begin : g_bad_latency
    $error("ram_frame_reader: DATA_W*2*HALF_PERIOD must exceed RD_LAT+2");
  end
  if ((HALF_SIZE <= 0) || ((HALF_SIZE & (HALF_SIZE - 1)) != 0) || (HALF_SIZE > (1 << ADDR_W))) begin : g_bad_half
    $error("ram_frame_reader: HALF_SIZE must be a power of two dividing 2**ADDR_W");
  end

  rd_state_e         state_q, state_d;
  logic [PC_W-1:0]   pcnt_q, pcnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [ADDR_W-1:0] rdaddress_q, rdaddress_d;
  logic              buf_switch_q, buf_switch_d;
  logic              word_strobe_q, word_strobe_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              enc_load, enc_bit, enc_dout, bit_done;
  logic              prime_last, word_last, load_word, half_end;
  logic [ADDR_W-1:0] word_addr;

  manchester_encoder #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_enc (
    .clk_i      (clk),
    .reset_i    (reset),
    .bit_i      (enc_bit),
    .load_i     (enc_load),
    .dout_o     (enc_dout),
    .bit_done_o (bit_done)
  );

  // rdaddress already points one past the word on the line.
  assign word_addr  = rdaddress_q - ADDR_W'(1);
  assign half_end   = (word_addr == ADDR_W'(HALF_SIZE - 1)) || (word_addr == '1);
  assign prime_last = (state_q == PRIME) && (pcnt_q == PC_LAST);
  assign word_last  = (state_q == SHIFT) && (cyc_q == CYC_LAST);
  assign load_word  = prime_last || (word_last && enable);

  always_comb begin
    state_d       = state_q;
    pcnt_d        = '0;
    cyc_d         = '0;
    rdaddress_d   = rdaddress_q;
    buf_switch_d  = buf_switch_q;
    word_strobe_d = load_word;
    shreg_d       = shreg_q;
    hold_d        = hold_q;
    enc_load      = 1'b0;
    enc_bit       = shreg_q[DATA_W-2];
    case (state_q)
      IDLE: begin
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        pcnt_d = pcnt_q + PC_W'(1);
        if (prime_last) begin
          state_d     = SHIFT;
          shreg_d     = q;
          enc_load    = 1'b1;
          enc_bit     = q[DATA_W-1];
          rdaddress_d = rdaddress_q + ADDR_W'(1);
        end
      end
      SHIFT: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == CYC_FETCH) hold_d = q;
        // Toggle lands one clock early so it is visible on the word's last clock.
        if ((cyc_q == CYC_PRELAST) && half_end) buf_switch_d = ~buf_switch_q;
        if (word_last) begin
          cyc_d = '0;
          if (enable) begin
            shreg_d     = hold_q;
            enc_load    = 1'b1;
            enc_bit     = hold_q[DATA_W-1];
            rdaddress_d = rdaddress_q + ADDR_W'(1);
          end else begin
            state_d = IDLE;
          end
        end else if (bit_done) begin
          shreg_d  = shreg_q << 1;
          enc_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pcnt_q        <= '0;
      cyc_q         <= '0;
      rdaddress_q   <= '0;
      buf_switch_q  <= 1'b0;
      word_strobe_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      cyc_q         <= cyc_d;
      rdaddress_q   <= rdaddress_d;
      buf_switch_q  <= buf_switch_d;
      word_strobe_q <= word_strobe_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    hold_q  <= hold_d;
  end

  assign rdaddress   = rdaddress_q;
  assign dout        = (state_q == SHIFT) && enc_dout;
  assign word_strobe = word_strobe_q;
  assign buf_switch  = buf_switch_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_frame_reader.sv
// Scoreboarded bench for ram_frame_reader: decodes the Manchester line word by
// word and compares against the RAM contents expected at each address.
module tb_ram_frame_reader;

  // Smaller address space so two full wraps fit in a short run.
  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 12;
  localparam int HALF_SIZE   = 256;
  localparam int HALF_PERIOD = 2;
  localparam int RD_LAT      = 2;
  localparam int NW          = 1 << ADDR_W;
  localparam int WC          = DATA_W * 2 * HALF_PERIOD;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] q = '0;
  logic [DATA_W-1:0] pipe1 = '0;
  logic [ADDR_W-1:0] rdaddress;
  logic              dout, word_strobe, buf_switch, busy;

  logic [DATA_W-1:0] mem [NW];
  logic [DATA_W-1:0] exp_q [$];

  int checks = 0;
  int failures = 0;
  bit bs_model = 1'b0;

  logic [WC-1:0]     cap_smp;
  logic [DATA_W-1:0] cap_word;
  bit                cap_manch_ok, cap_strobe_ok, cap_busy_ok, strobe_seen;
  logic              cap_bs0, cap_bs_pre, cap_bs_last;

  ram_frame_reader #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .HALF_SIZE   (HALF_SIZE),
    .HALF_PERIOD (HALF_PERIOD),
    .RD_LAT      (RD_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .q           (q),
    .rdaddress   (rdaddress),
    .dout        (dout),
    .word_strobe (word_strobe),
    .buf_switch  (buf_switch),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Two-register read port: q follows rdaddress by RD_LAT=2 clocks.
  always @(posedge clk) begin
    pipe1 <= mem[rdaddress];
    q     <= pipe1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic fill_mem();
    for (int i = 0; i < NW; i++) mem[i] = DATA_W'(i * 3 + 'h155);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_strobe();
    strobe_seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (word_strobe === 1'b1) begin
        strobe_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called on the first clock of a word; returns on the first clock after it.
  task automatic capture_word(input int drop_at, input int rise_at);
    logic v;
    cap_manch_ok = 1'b1; cap_strobe_ok = 1'b1; cap_busy_ok = 1'b1;
    cap_smp = '0; cap_word = '0; cap_bs0 = 1'b0; cap_bs_pre = 1'b0; cap_bs_last = 1'b0;
    for (int i = 0; i < WC; i++) begin
      cap_smp[WC-1-i] = dout;
      if (word_strobe !== ((i == 0) ? 1'b1 : 1'b0)) cap_strobe_ok = 1'b0;
      if (busy !== 1'b1) cap_busy_ok = 1'b0;
      if (i == 0) cap_bs0 = buf_switch;
      if (i == WC - 2) cap_bs_pre = buf_switch;
      if (i == WC - 1) cap_bs_last = buf_switch;
      if (i == drop_at) enable = 1'b0;
      if (i == rise_at) enable = 1'b1;
      @(negedge clk);
    end
    for (int b = 0; b < DATA_W; b++) begin
      v = cap_smp[WC-1-2*HALF_PERIOD*b];
      for (int k = 0; k < 2 * HALF_PERIOD; k++)
        if (cap_smp[WC-1-2*HALF_PERIOD*b-k] !== ((k < HALF_PERIOD) ? v : ~v)) cap_manch_ok = 1'b0;
      cap_word[DATA_W-1-b] = v;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rdaddress !== '0) begin failures++; $display("FAIL reset_rdaddress got=%0d exp=0", rdaddress); end
    checks++; if (dout !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", dout); end
    checks++; if (word_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", word_strobe); end
    checks++; if (buf_switch !== 1'b0) begin failures++; $display("FAIL reset_buf_switch got=%b exp=0", buf_switch); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (5) @(negedge clk);
    checks++; if ({busy, dout} !== 2'b00) begin failures++; $display("FAIL idle_hold busy,dout got=%b exp=00", {busy, dout}); end
  endtask

  task automatic test_word_pattern();
    logic [DATA_W-1:0] e;
    logic [15:0] first16;
    fill_mem();
    mem[0] = 12'hA5C;
    do_reset();
    exp_q.delete();
    exp_q.push_back(12'hA5C);
    enable = 1'b1;
    wait_strobe();
    checks++; if (!strobe_seen) begin failures++; $display("FAIL pattern_start got=no_strobe exp=strobe"); end
    checks++; if (rdaddress !== ADDR_W'(1)) begin failures++; $display("FAIL pattern_rdaddr got=%0d exp=1", rdaddress); end
    capture_word(5, -1);
    first16 = cap_smp[WC-1 -: 16];
    checks++; if (first16 !== 16'b1100_0011_1100_0011) begin failures++; $display("FAIL pattern_first16 got=%b exp=1100001111000011", first16); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (cap_word !== e) begin failures++; $display("FAIL pattern_word got=%h exp=%h", cap_word, e); end
    checks++; if (!cap_strobe_ok) begin failures++; $display("FAIL pattern_strobe got=bad exp=clock0_only"); end
    checks++; if (!cap_manch_ok) begin failures++; $display("FAIL pattern_manchester got=bad exp=valid"); end
    checks++; if ({busy, dout} !== 2'b00) begin failures++; $display("FAIL pattern_stop busy,dout got=%b exp=00", {busy, dout}); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] e;
    fill_mem();
    mem[0] = 12'hFFF; mem[1] = 12'h000; mem[2] = 12'h800; mem[3] = 12'h001;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
    enable = 1'b1;
    wait_strobe();
    checks++; if (!strobe_seen) begin failures++; $display("FAIL b2b_start got=no_strobe exp=strobe"); end
    for (int w = 0; w < 4; w++) begin
      checks++; if (rdaddress !== ADDR_W'(w + 1)) begin failures++; $display("FAIL b2b_rdaddr w=%0d got=%0d exp=%0d", w, rdaddress, w + 1); end
      // word 1 carries a brief enable glitch that must be ignored mid-word
      capture_word((w == 1 || w == 3) ? 5 : -1, (w == 1) ? 12 : -1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++; if (cap_word !== e) begin failures++; $display("FAIL b2b_word w=%0d got=%h exp=%h", w, cap_word, e); end
      checks++; if (!(cap_manch_ok && cap_strobe_ok && cap_busy_ok)) begin failures++;
        $display("FAIL b2b_line w=%0d got=manch%0d_strobe%0d_busy%0d exp=all1", w, cap_manch_ok, cap_strobe_ok, cap_busy_ok); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_stop busy got=%b exp=0", busy); end
  endtask

  task automatic test_stop_resume();
    logic [DATA_W-1:0] e;
    fill_mem();
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(mem[i]);
    enable = 1'b1;
    wait_strobe();
    checks++; if (!strobe_seen) begin failures++; $display("FAIL stop_start got=no_strobe exp=strobe"); end
    for (int w = 0; w < 6; w++) begin
      capture_word((w == 5) ? 10 : -1, -1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++; if (cap_word !== e) begin failures++; $display("FAIL stop_word w=%0d got=%h exp=%h", w, cap_word, e); end
      checks++; if (!(cap_manch_ok && cap_strobe_ok && cap_busy_ok)) begin failures++; $display("FAIL stop_line w=%0d got=bad exp=valid", w); end
    end
    checks++; if ({busy, dout, word_strobe} !== 3'b000) begin failures++; $display("FAIL stop_idle busy,dout,strobe got=%b exp=000", {busy, dout, word_strobe}); end
    checks++; if (rdaddress !== ADDR_W'(6)) begin failures++; $display("FAIL stop_rdaddr got=%0d exp=6", rdaddress); end
    repeat (5) @(negedge clk);
    checks++; if ({busy, dout} !== 2'b00) begin failures++; $display("FAIL stop_hold busy,dout got=%b exp=00", {busy, dout}); end
    exp_q.push_back(mem[6]);
    enable = 1'b1;
    wait_strobe();
    checks++; if (!strobe_seen) begin failures++; $display("FAIL resume_start got=no_strobe exp=strobe"); end
    checks++; if (rdaddress !== ADDR_W'(7)) begin failures++; $display("FAIL resume_rdaddr got=%0d exp=7", rdaddress); end
    capture_word(10, -1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (cap_word !== e) begin failures++; $display("FAIL resume_word got=%h exp=%h", cap_word, e); end
  endtask

  task automatic test_half_buffer();
    logic [DATA_W-1:0] e;
    logic bs_exp;
    int a;
    fill_mem();
    do_reset();
    exp_q.delete();
    bs_exp = 1'b0;
    enable = 1'b1;
    wait_strobe();
    checks++; if (!strobe_seen) begin failures++; $display("FAIL half_start got=no_strobe exp=strobe"); end
    for (int w = 0; w < 2 * NW + HALF_SIZE; w++) begin
      a = w % NW;
      exp_q.push_back(mem[ADDR_W'(a)]);
      checks++; if (rdaddress !== ADDR_W'((a + 1) % NW)) begin failures++; $display("FAIL half_rdaddr w=%0d got=%0d exp=%0d", w, rdaddress, (a + 1) % NW); end
      capture_word(-1, -1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++; if (cap_word !== e) begin failures++; $display("FAIL half_word w=%0d got=%h exp=%h", w, cap_word, e); end
      checks++; if (!(cap_manch_ok && cap_strobe_ok)) begin failures++; $display("FAIL half_line w=%0d got=bad exp=valid", w); end
      checks++; if ({cap_bs0, cap_bs_pre} !== {bs_exp, bs_exp}) begin failures++; $display("FAIL half_bs_mid w=%0d got=%b%b exp=%b%b", w, cap_bs0, cap_bs_pre, bs_exp, bs_exp); end
      if (a == HALF_SIZE - 1 || a == NW - 1) bs_exp = ~bs_exp;
      checks++; if (cap_bs_last !== bs_exp) begin failures++; $display("FAIL half_bs_last w=%0d got=%b exp=%b", w, cap_bs_last, bs_exp); end
    end
    bs_model = bs_exp;
  endtask

  task automatic test_reset_midword();
    logic [DATA_W-1:0] e;
    checks++; if (buf_switch !== bs_model) begin failures++; $display("FAIL rstmid_pre_bs got=%b exp=%b", buf_switch, bs_model); end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checks++; if (dout !== 1'b0) begin failures++; $display("FAIL rstmid_dout got=%b exp=0", dout); end
    checks++; if (rdaddress !== '0) begin failures++; $display("FAIL rstmid_rdaddr got=%0d exp=0", rdaddress); end
    checks++; if (buf_switch !== 1'b0) begin failures++; $display("FAIL rstmid_bs got=%b exp=0", buf_switch); end
    checks++; if ({busy, word_strobe} !== 2'b00) begin failures++; $display("FAIL rstmid_busy,strobe got=%b exp=00", {busy, word_strobe}); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle busy got=%b exp=0", busy); end
    exp_q.delete();
    exp_q.push_back(mem[0]);
    enable = 1'b1;
    wait_strobe();
    checks++; if (rdaddress !== ADDR_W'(1)) begin failures++; $display("FAIL rstmid_restart_rdaddr got=%0d exp=1", rdaddress); end
    capture_word(5, -1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (cap_word !== e) begin failures++; $display("FAIL rstmid_restart_word got=%h exp=%h", cap_word, e); end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_word_pattern();
    test_back_to_back();
    test_stop_resume();
    test_half_buffer();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
